// File: rtl/fib_pkg.sv
// Shared types and constants for the fibonacci job dispatcher.
package fib_pkg;

   localparam int unsigned FIB_WIDTH    = 16;
   // fib(24)=46368 is the last value representable in 16 bits
   localparam int unsigned FIB_MAX_N_16 = 24;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      GUARD,
      WAIT,
      RESP
   } fib_disp_state_t;

endpackage

// File: rtl/fib_req_fifo.sv
// Request FIFO: registered storage, head visible the cycle after push.
module fib_req_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ready;
   assign do_pop  = pop & ~empty;
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Occupancy after this cycle's push/pop
   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + CW'(1);
      end else if (do_pop && !do_push) begin
         count_next = count - CW'(1);
      end
   end

   // Pointers, occupancy and registered not-full flag (low while in reset)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         ready <= (count_next != CW'(DEPTH));
      end
   end

   // Storage array needs no reset; only entries inside count are ever read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fib_dispatch.sv
// Job dispatcher: queues n requests, runs them one at a time on the
// fibonacci core and returns (n, fib(n), err) on a valid/ready port.
module fib_dispatch
   import fib_pkg::*;
#(
   parameter int unsigned WIDTH   = FIB_WIDTH,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned MAX_N   = FIB_MAX_N_16,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_n,
   output logic [WIDTH-1:0] core_din,
   output logic             core_start,
   input  logic [WIDTH-1:0] core_dout,
   input  logic             core_done,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_n,
   output logic [WIDTH-1:0] rsp_fib,
   output logic             rsp_err,
   output logic [15:0]      jobs_done
);

   localparam int unsigned      TW      = $clog2(TIMEOUT);
   localparam logic [WIDTH-1:0] MAX_N_W = WIDTH'(MAX_N);
   localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

   fib_disp_state_t  state, state_d;
   logic [WIDTH-1:0] cur_n, cur_n_d;
   logic [WIDTH-1:0] fib_q, fib_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] din_q, din_d;
   logic [TW-1:0]    timer, timer_d;
   logic [15:0]      jobs, jobs_d;
   logic             fifo_pop;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_head;

   fib_req_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_valid),
      .pop   (fifo_pop),
      .din   (req_n),
      .dout  (fifo_head),
      .empty (fifo_empty),
      .ready (req_ready)
   );

   // Next-state and datapath decisions for the single in-flight job
   always_comb begin
      state_d  = state;
      cur_n_d  = cur_n;
      fib_d    = fib_q;
      err_d    = err_q;
      din_d    = din_q;
      timer_d  = timer;
      jobs_d   = jobs;
      fifo_pop = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cur_n_d  = fifo_head;
               fib_d    = '0;
               err_d    = 1'b0;
               if (fifo_head > MAX_N_W) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  din_d   = fifo_head;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: state_d = GUARD;
         GUARD: begin
            // done may still be high from the previous job; skip this cycle
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (core_done) begin
               fib_d   = core_dout;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timer == T_LAST) begin
               fib_d   = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               jobs_d  = jobs + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, job registers and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cur_n      <= '0;
         fib_q      <= '0;
         err_q      <= 1'b0;
         din_q      <= '0;
         timer      <= '0;
         jobs       <= '0;
         core_start <= 1'b0;
         rsp_valid  <= 1'b0;
      end else begin
         state      <= state_d;
         cur_n      <= cur_n_d;
         fib_q      <= fib_d;
         err_q      <= err_d;
         din_q      <= din_d;
         timer      <= timer_d;
         jobs       <= jobs_d;
         core_start <= (state_d == ISSUE);
         rsp_valid  <= (state_d == RESP);
      end
   end

   assign core_din  = din_q;
   assign rsp_n     = cur_n;
   assign rsp_fib   = fib_q;
   assign rsp_err   = err_q;
   assign jobs_done = jobs;

endmodule
